fir_sample_sequencer: RTL and testbench
=======================================

# fir_sample_sequencer

Control block for the FIR lab datapath: debounces the `go` pushbutton, captures the 8-bit switch sample, and sequences one FIR step per press. It issues a single-cycle `fir_go` strobe to the FIR and waits a fixed latency. It then latches the 16-bit FIR output into a hold register that feeds the binary-to-BCD converter. It also generates the 4-digit anode scan for the seven-segment display, replacing free-running `go` wiring between switches, FIR and display.

## Interface

- `DB_COUNT`, 500000: consecutive synchronized cycles a button level must hold to be accepted (10 ms at 50 MHz).
- `FIR_LATENCY`, 2: cycles from `fir_go` strobe to valid `fir_y`, ≥1.
- `SCAN_DIV`, 50000: clock cycles per display digit slot, ≥2.
- `clk` in 1: system clock, all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `go_btn` in 1: raw pushbutton, asynchronous to `clk`, bounces.
- `sw_in` in 8: switch sample value.
- `fir_y` in 16: FIR filter output.
- `sample` out 8: registered sample presented to FIR `in`.
- `fir_go` out 1: one-cycle step strobe to FIR.
- `y_hold` out 16: latched FIR result for BCD conversion.
- `busy` out 1: high while a step is in progress.
- `sample_count` out 8: completed steps, wraps 255→0.
- `digit_sel` out 4: active-low one-hot anode select, bit 0 = AN0.

## Operation

- Reset values:
  - Outputs: `sample`=0, `fir_go`=0, `y_hold`=0, `busy`=0, `sample_count`=0, `digit_sel`=4'b1110.
  - Internal state: FSM in IDLE, debounce stable level 0, all counters 0.
- Synchronizer: `go_btn` passes through two flops (`s2`).
- Debounce:
  - Stable level `db` plus counter `dbc`.
  - If `s2`==`db`: `dbc`←0.
  - Else `dbc` increments; when `dbc` reaches `DB_COUNT-1`, `db`←`s2` and `dbc`←0.
- Press event: one-cycle pulse `press` = `db` & ~`db_d`, where `db_d` is `db` delayed one cycle. Releases generate nothing.
- FSM states:
  - IDLE: `busy`=0. If `press`, go to LOAD.
  - LOAD: `sample`←`sw_in`. Go to STROBE.
  - STROBE: `fir_go`=1 (registered, high exactly this state's cycle). Latency counter `lc`←0. Go to WAIT.
  - WAIT: `lc` increments each cycle. When `lc`==`FIR_LATENCY-1`, go to LATCH.
  - LATCH: `y_hold`←`fir_y`, `sample_count`←`sample_count`+1 mod 256. Go to IDLE.
- `busy`=1 in LOAD, STROBE, WAIT, LATCH.
- A `press` arriving while not in IDLE is dropped, not queued.
- `sample` and `y_hold` change only in LOAD and LATCH respectively; they hold their values otherwise.
- `sw_in` changes outside LOAD have no effect.
- Display scan:
  - Counter `sc` runs 0..`SCAN_DIV-1` continuously, independent of the FSM.
  - On wrap, digit index `di` increments mod 4.
  - `digit_sel` = ~(1<<`di`), registered.

## Timing

- Button to `press`:
  - `press` fires `2+DB_COUNT+1` cycles after `go_btn` rises cleanly (2 sync, DB_COUNT count, 1 edge).
  - A bounce that returns before the count completes resets `dbc` and produces no press.
- `press` in cycle T:
  - LOAD at T+1.
  - STROBE/`fir_go`=1 at T+2, with `sample` already valid.
  - WAIT at T+3..T+2+`FIR_LATENCY`.
  - LATCH at T+3+`FIR_LATENCY`.
  - `y_hold` and `sample_count` update visible at T+4+`FIR_LATENCY`.
- `busy` high for exactly 3+`FIR_LATENCY` cycles per press.
- Minimum press-to-press interval accepted is bounded by debounce (two DB_COUNT windows), always longer than a step for default parameters.
- `digit_sel` advances every `SCAN_DIV` cycles. The first change after reset occurs at cycle `SCAN_DIV`, with sequence 1110→1101→1011→0111→1110.
- Reset mid-step: `rst` asserted in any state returns all outputs to reset values immediately (asynchronous). No `fir_go` is issued after reset release until a new press.
- Button held through reset release: `db`=0 after reset, so a press fires once the level is re-qualified.

## Test plan

- Parameters for all scenarios: `DB_COUNT`=4, `FIR_LATENCY`=2, `SCAN_DIV`=4.
- Clean press: `sw_in`=8'h2A, `go_btn` held high 20 cycles, `fir_y` driven 16'h1234 from `fir_go`+2.
  - Exactly one `fir_go` pulse.
  - `sample`=8'h2A at the strobe.
  - `y_hold`=16'h1234.
  - `sample_count`=1.
  - `busy` high 5 cycles.
- Bounce: `go_btn` toggles every 2 cycles for 16 cycles, then stays low.
  - No `press`, no `fir_go`, `sample_count`=0.
- Press while busy: force a second `db` rising edge during WAIT.
  - Dropped; a single step completes, `sample_count`=1.
- Wrap: 256 clean presses → `sample_count`=0, `y_hold` equals last latched `fir_y`.
- Reset mid-step: assert `rst` in WAIT.
  - Outputs return at once to 0 / 4'b1110.
  - No `fir_go` after release without a new press.
- Scan: from reset, sample `digit_sel` every 4 cycles.
  - Sequence 1110, 1101, 1011, 0111, 1110.
  - Unaffected by concurrent steps.

Source files
------------

// File: rtl/fir_sample_sequencer.sv
// fir_sample_sequencer: debounces the go button, captures the switch sample,
// runs one FIR step per press (strobe, fixed-latency wait, result latch) and
// drives the 4-digit active-low anode scan for the seven-segment display.
module fir_sample_sequencer #(
  parameter int DB_COUNT    = 500000,
  parameter int FIR_LATENCY = 2,
  parameter int SCAN_DIV    = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go_btn,
  input  logic [7:0]  sw_in,
  input  logic [15:0] fir_y,
  output logic [7:0]  sample,
  output logic        fir_go,
  output logic [15:0] y_hold,
  output logic        busy,
  output logic [7:0]  sample_count,
  output logic [3:0]  digit_sel
);

  localparam int DBC_W = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam int LC_W  = (FIR_LATENCY > 1) ? $clog2(FIR_LATENCY) : 1;
  localparam int SC_W  = $clog2(SCAN_DIV);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STROBE, S_WAIT, S_LATCH} state_t;

  logic [1:0]       sync_q;
  logic             db_q, db_d, db_dly_q;
  logic [DBC_W-1:0] dbc_q, dbc_d;
  logic             press;

  state_t           state_q;
  logic [LC_W-1:0]  lc_q;
  logic [7:0]       sample_q, cnt_q;
  logic [15:0]      y_hold_q;
  logic             fir_go_q, busy_q;

  logic [SC_W-1:0]  sc_q;
  logic [1:0]       di_q;
  logic [3:0]       digit_sel_q;

  // Two-flop synchronizer for the asynchronous pushbutton; sync_q[1] is s2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], go_btn};
  end

  // Debounce next state: a new level is accepted only after it has differed
  // from the stable level for DB_COUNT consecutive cycles.
  always_comb begin
    db_d  = db_q;
    dbc_d = dbc_q;
    if (sync_q[1] == db_q) begin
      dbc_d = '0;
    end else if (dbc_q == DBC_W'(DB_COUNT - 1)) begin
      db_d  = sync_q[1];
      dbc_d = '0;
    end else begin
      dbc_d = dbc_q + 1'b1;
    end
  end

  // Debounce state plus one-cycle delayed copy for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q     <= 1'b0;
      dbc_q    <= '0;
      db_dly_q <= 1'b0;
    end else begin
      db_q     <= db_d;
      dbc_q    <= dbc_d;
      db_dly_q <= db_q;
    end
  end

  // Only the rising edge of the stable level starts a step; releases do nothing.
  assign press = db_q & ~db_dly_q;

  // Step sequencer with registered outputs; presses outside IDLE are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lc_q     <= '0;
      sample_q <= 8'h00;
      y_hold_q <= 16'h0000;
      cnt_q    <= 8'h00;
      fir_go_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      fir_go_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (press) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          sample_q <= sw_in;
          fir_go_q <= 1'b1;       // high for exactly the STROBE cycle
          state_q  <= S_STROBE;
        end
        S_STROBE: begin
          lc_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          lc_q <= lc_q + 1'b1;
          if (lc_q == LC_W'(FIR_LATENCY - 1)) state_q <= S_LATCH;
        end
        S_LATCH: begin
          y_hold_q <= fir_y;
          cnt_q    <= cnt_q + 8'd1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running display scan, independent of the step sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_q        <= '0;
      di_q        <= 2'd0;
      digit_sel_q <= 4'b1110;
    end else if (sc_q == SC_W'(SCAN_DIV - 1)) begin
      sc_q        <= '0;
      di_q        <= di_q + 2'd1;
      digit_sel_q <= ~(4'b0001 << (di_q + 2'd1));
    end else begin
      sc_q <= sc_q + 1'b1;
    end
  end

  assign sample       = sample_q;
  assign fir_go       = fir_go_q;
  assign y_hold       = y_hold_q;
  assign busy         = busy_q;
  assign sample_count = cnt_q;
  assign digit_sel    = digit_sel_q;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer: a press/step timeline model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_fir_sample_sequencer;

  localparam int DB = 4;
  localparam int L  = 2;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst, go_btn;
  logic [7:0]  sw_in;
  logic [15:0] fir_y;
  logic [7:0]  sample, sample_count;
  logic        fir_go, busy;
  logic [15:0] y_hold;
  logic [3:0]  digit_sel;

  int checks = 0;
  int errors = 0;

  fir_sample_sequencer #(.DB_COUNT(DB), .FIR_LATENCY(L), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .go_btn(go_btn), .sw_in(sw_in), .fir_y(fir_y),
    .sample(sample), .fir_go(fir_go), .y_hold(y_hold), .busy(busy),
    .sample_count(sample_count), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_age: 0 idle, 1 = first busy cycle after the press cycle, ..., 3+L = last.
  int         m_age;
  int         m_n;
  logic       m_press, m_db, m_g, m_s2, m_prev, m_all;
  logic       win [0:DB-1];
  logic [7:0] m_sample, m_cnt;
  logic [15:0] m_y;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_age = 0; m_n = 0; m_press = 0; m_db = 0; m_g = 0; m_s2 = 0;
      m_sample = 0; m_cnt = 0; m_y = 0;
      for (int i = 0; i < DB; i++) win[i] = 1'b0;
    end else begin
      if (m_age == 0) begin
        if (m_press) m_age = 1;
      end else if (m_age == 3 + L) begin
        m_y = fir_y; m_cnt = m_cnt + 8'd1; m_age = 0;
      end else begin
        if (m_age == 1) m_sample = sw_in;
        m_age++;
      end
      // accepted level flips once the last DB synchronized samples all differ
      for (int i = DB - 1; i > 0; i--) win[i] = win[i-1];
      win[0] = m_s2;
      m_all = 1'b1;
      for (int i = 0; i < DB; i++) if (win[i] == m_db) m_all = 1'b0;
      m_prev = m_db;
      if (m_all) m_db = ~m_db;
      m_press = m_db & ~m_prev;
      m_s2 = m_g;
      m_g  = go_btn;
      m_n++;
    end
  end

  // ---------------- compare process ----------------
  int          fg_cnt, busy_cnt;
  logic [7:0]  samp_at_go;
  logic [3:0]  exp_ds;

  initial forever begin
    @(posedge clk);
    #1;
    if (!rst) begin
      exp_ds = ~(4'b0001 << ((m_n / SD) % 4));
      check("sample",    sample,       m_sample);
      check("fir_go",    fir_go,       m_age == 2);
      check("busy",      busy,         m_age != 0);
      check("y_hold",    y_hold,       m_y);
      check("count",     sample_count, m_cnt);
      check("digit_sel", digit_sel,    exp_ds);
      if (fir_go) begin fg_cnt++; samp_at_go = sample; end
      if (busy) busy_cnt++;
    end
  end

  // FIR stand-in: junk while computing, y_next valid from fir_go+2, junk later.
  logic [15:0] y_next;
  int          fy_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (fy_cnt == 3) fir_y = y_next;
    if (fy_cnt == 1) fir_y = 16'hDEAD;
    if (fy_cnt > 0) fy_cnt--;
    if (fir_go) begin fir_y = 16'hBAD0; fy_cnt = 4; end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sample"}, sample,       8'h00);
    check({tag, "_fir_go"}, fir_go,       1'b0);
    check({tag, "_y_hold"}, y_hold,       16'h0000);
    check({tag, "_busy"},   busy,         1'b0);
    check({tag, "_count"},  sample_count, 8'h00);
    check({tag, "_dsel"},   digit_sel,    4'b1110);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;
    fg_cnt = 0; busy_cnt = 0;
  endtask

  // Waits (bounded) for the strobe; returns at the negedge of the STROBE cycle.
  task automatic wait_go(input string nm);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (fir_go) seen = 1;
    end
    check({nm, "_go_seen"}, seen, 1'b1);
  endtask

  initial begin
    rst = 1'b0; go_btn = 1'b0; sw_in = 8'h00; fir_y = 16'h0000; y_next = 16'h0000;
    fg_cnt = 0; busy_cnt = 0; samp_at_go = 8'h00;
    #2 rst = 1'b1;
    #1 check_reset_vals("init");

    // Scan from reset, with a step running concurrently.
    @(negedge clk);
    rst = 1'b0; go_btn = 1'b1; sw_in = 8'h11; y_next = 16'h0077;
    check("scan0", digit_sel, 4'b1110);
    repeat (4) @(posedge clk); #1 check("scan1", digit_sel, 4'b1101);
    repeat (4) @(posedge clk); #1 check("scan2", digit_sel, 4'b1011);
    repeat (4) @(posedge clk); #1 check("scan3", digit_sel, 4'b0111);
    repeat (4) @(posedge clk); #1 check("scan4", digit_sel, 4'b1110);
    @(negedge clk); go_btn = 1'b0;
    tick(20);
    check("scan_step_count", sample_count, 8'd1);

    // Clean press.
    do_reset();
    sw_in = 8'h2A; y_next = 16'h1234;
    go_btn = 1'b1; tick(20);
    go_btn = 1'b0; sw_in = 8'hC3; tick(20);
    check("clean_pulses", fg_cnt,       1);
    check("clean_samp",   samp_at_go,   8'h2A);
    check("clean_sample", sample,       8'h2A);
    check("clean_y",      y_hold,       16'h1234);
    check("clean_count",  sample_count, 8'd1);
    check("clean_busy",   busy_cnt,     5);

    // Bounce: runs of 2 never qualify.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      go_btn = 1'b1; tick(2);
      go_btn = 1'b0; tick(2);
    end
    tick(20);
    check("bounce_pulses", fg_cnt,       0);
    check("bounce_count",  sample_count, 8'd0);
    check("bounce_busy",   busy_cnt,     0);

    // Second press edge during WAIT is dropped.
    do_reset();
    sw_in = 8'h55; y_next = 16'hABCD;
    go_btn = 1'b1;
    wait_go("busy");
    @(negedge clk);
    force dut.db_dly_q = 1'b0;
    #1 check("busy_forced_press", dut.press, 1'b1);
    @(negedge clk);
    release dut.db_dly_q;
    tick(20);
    go_btn = 1'b0; tick(20);
    check("busy_pulses", fg_cnt,       1);
    check("busy_count",  sample_count, 8'd1);
    check("busy_y",      y_hold,       16'hABCD);

    // Wrap after 256 presses.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      sw_in = 8'(i); y_next = 16'(i * 97 + 5);
      go_btn = 1'b1; tick(12);
      go_btn = 1'b0; tick(12);
    end
    tick(10);
    check("wrap_pulses", fg_cnt,       256);
    check("wrap_count",  sample_count, 8'd0);
    check("wrap_y",      y_hold,       16'h60A4);
    check("wrap_sample", sample,       8'hFF);

    // Reset in WAIT.
    do_reset();
    sw_in = 8'h99; y_next = 16'h4321;
    go_btn = 1'b1;
    wait_go("mid");
    go_btn = 1'b0;
    @(negedge clk);
    check("mid_in_step", busy, 1'b1);
    rst = 1'b1;
    #1 check_reset_vals("mid");
    @(negedge clk);
    rst = 1'b0; fg_cnt = 0;
    tick(30);
    check("mid_no_go", fg_cnt,       0);
    check("mid_count", sample_count, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
